// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX_IN, PRESCALE-times oversampling, 3-sample majority vote,
// optional parity check; result strobes (DATA_VALID / PAR_ERR / STP_ERR) are exactly one cycle wide.
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYPE,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int unsigned BCW = $clog2(DATA_WIDTH + 3);
   localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] P_TWO = PRESCALE_W'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, rx_s_q;
   logic [PRESCALE_W-1:0]  edge_q, edge_d;
   logic [BCW-1:0]         bit_q, bit_d;
   logic [2:0]             samp_q, samp_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
   logic                   par_en_q, par_en_d;
   logic                   par_type_q, par_type_d;
   logic                   par_flag_q, par_flag_d;
   logic [DATA_WIDTH-1:0]  pdata_q, pdata_d;
   logic                   dv_q, dv_d;
   logic                   perr_q, perr_d;
   logic                   serr_q, serr_d;

   logic [PRESCALE_W-1:0]  half;
   logic                   last_edge, pre_last_edge, sample_edge, vote;

   assign half          = prescale_q >> 1;
   assign last_edge     = (edge_q == prescale_q - P_ONE);
   assign pre_last_edge = (edge_q == prescale_q - P_TWO);
   assign sample_edge   = (edge_q == half - P_ONE) || (edge_q == half) || (edge_q == half + P_ONE);
   assign vote          = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

   always_comb begin
      state_d    = state_q;
      edge_d     = edge_q;
      bit_d      = bit_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      par_flag_d = par_flag_q;
      pdata_d    = pdata_q;
      dv_d       = 1'b0;
      perr_d     = 1'b0;
      serr_d     = 1'b0;

      if (state_q != S_IDLE) begin
         edge_d = last_edge ? '0 : edge_q + P_ONE;
         if (last_edge) bit_d = bit_q + BCW'(1);
         if (sample_edge) samp_d = {samp_q[1:0], rx_s_q};
      end

      case (state_q)
         S_IDLE: begin
            edge_d = '0;
            bit_d  = '0;
            // The detection cycle itself is edge 0 of the start bit.
            if (!rx_s_q) begin
               state_d    = S_START;
               edge_d     = P_ONE;
               prescale_d = PRESCALE;
               par_en_d   = PAR_EN;
               par_type_d = PAR_TYPE;
               par_flag_d = 1'b0;
            end
         end
         S_START: begin
            if (last_edge) begin
               if (vote) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (last_edge) begin
               shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
               if (bit_q == BCW'(DATA_WIDTH)) state_d = par_en_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (last_edge) begin
               if (vote != (^shift_q ^ par_type_q)) par_flag_d = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Result registered one edge early so the strobe coincides with the stop bit's final cycle.
            if (pre_last_edge) begin
               serr_d = ~vote;
               perr_d = par_flag_q;
               if (vote && !par_flag_q) begin
                  dv_d    = 1'b1;
                  pdata_d = shift_q;
               end
            end
            if (last_edge) begin
               state_d = S_IDLE;
               bit_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            edge_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         edge_q     <= '0;
         bit_q      <= '0;
         samp_q     <= '0;
         shift_q    <= '0;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         par_flag_q <= 1'b0;
         pdata_q    <= '0;
         dv_q       <= 1'b0;
         perr_q     <= 1'b0;
         serr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= RX_IN;
         rx_s_q     <= sync1_q;
         edge_q     <= edge_d;
         bit_q      <= bit_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         prescale_q <= prescale_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         par_flag_q <= par_flag_d;
         pdata_q    <= pdata_d;
         dv_q       <= dv_d;
         perr_q     <= perr_d;
         serr_q     <= serr_d;
      end
   end

   assign P_DATA     = pdata_q;
   assign DATA_VALID = dv_q;
   assign PAR_ERR    = perr_q;
   assign STP_ERR    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, result strobes logged by a negedge monitor.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] PRESCALE;
   logic       PAR_EN;
   logic       PAR_TYPE;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int dv_cnt   = 0;
   int pe_cnt   = 0;
   int se_cnt   = 0;
   int dv_cyc   = 0;
   int pe_cyc   = 0;
   int se_cyc   = 0;
   int start_cyc, start2;
   int dv0, pe0, se0;
   logic [7:0] dv_log [32];

   uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .PRESCALE  (PRESCALE),
      .PAR_EN    (PAR_EN),
      .PAR_TYPE  (PAR_TYPE),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR   (PAR_ERR),
      .STP_ERR   (STP_ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (DATA_VALID === 1'b1) begin
         if (dv_cnt < 32) dv_log[dv_cnt] = P_DATA;
         dv_cyc = cyc;
         dv_cnt++;
      end
      if (PAR_ERR === 1'b1) begin
         pe_cyc = cyc;
         pe_cnt++;
      end
      if (STP_ERR === 1'b1) begin
         se_cyc = cyc;
         se_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic snap();
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      se0 = se_cnt;
   endtask

   // Called just after a rising edge; each frame bit is held for p cycles.
   // spike >= 0 inverts that frame bit for the single cycle aligned with its centre sample.
   task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit pbit,
                             input bit stopb, input int spike);
      logic [10:0] bits;
      int n;
      n = pen ? 11 : 10;
      bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) bits[j+1] = d[j];
      if (pen) begin
         bits[9]  = pbit;
         bits[10] = stopb;
      end else begin
         bits[9]  = stopb;
         bits[10] = 1'b1;
      end
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < p; c++) begin
            RX_IN = bits[i] ^ ((i == spike) && (c == p / 2));
            @(posedge CLK);
            #1;
         end
      end
      RX_IN = 1'b1;
   endtask

   initial begin
      RST      = 1'b0;
      RX_IN    = 1'b1;
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYPE = 1'b0;
      #3;
      chk("reset_pdata", 32'(P_DATA), 32'h0);
      chk("reset_dv",    32'(DATA_VALID), 32'h0);
      chk("reset_perr",  32'(PAR_ERR), 32'h0);
      chk("reset_serr",  32'(STP_ERR), 32'h0);
      tick(3);
      RST = 1'b1;
      tick(4);

      // 1: P=8, no parity, 0xA5; strobe 2 sync cycles + 10*8-1 after the line falls
      snap();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
      tick(4);
      chk("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
      chk("t1_data",     32'(dv_log[dv0]), 32'hA5);
      chk("t1_latency",  32'(dv_cyc - start_cyc), 32'd81);
      chk("t1_no_err",   32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
      chk("t1_pdata",    32'(P_DATA), 32'hA5);

      // 2: P=16, even parity, 0x3C good (parity 0) then bad (parity 1)
      PRESCALE = 6'd16;
      PAR_EN   = 1'b1;
      PAR_TYPE = 1'b0;
      snap();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
      tick(4);
      chk("t2_dv_count", 32'(dv_cnt - dv0), 32'd1);
      chk("t2_data",     32'(P_DATA), 32'h3C);
      chk("t2_latency",  32'(dv_cyc - start_cyc), 32'd177);
      chk("t2_no_perr",  32'(pe_cnt - pe0), 32'd0);
      snap();
      send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
      tick(4);
      chk("t2b_perr_count", 32'(pe_cnt - pe0), 32'd1);
      chk("t2b_perr_lat",   32'(pe_cyc - start_cyc), 32'd177);
      chk("t2b_no_dv",      32'(dv_cnt - dv0), 32'd0);
      chk("t2b_no_serr",    32'(se_cnt - se0), 32'd0);
      chk("t2b_pdata_kept", 32'(P_DATA), 32'h3C);
      // odd parity: 0x3C has even ones, so odd parity bit is 1
      PAR_TYPE = 1'b1;
      snap();
      send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
      tick(4);
      chk("t2c_odd_dv",   32'(dv_cnt - dv0), 32'd1);
      chk("t2c_odd_perr", 32'(pe_cnt - pe0), 32'd0);

      // 3: P=8, 0x55 with stop bit 0, then a good frame to prove return to IDLE
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYPE = 1'b0;
      snap();
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1);
      tick(4);
      chk("t3_serr_count", 32'(se_cnt - se0), 32'd1);
      chk("t3_serr_lat",   32'(se_cyc - start_cyc), 32'd81);
      chk("t3_no_dv",      32'(dv_cnt - dv0), 32'd0);
      chk("t3_pdata_kept", 32'(P_DATA), 32'h3C);
      snap();
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, -1);
      tick(4);
      chk("t3_after_dv",   32'(dv_cnt - dv0), 32'd1);
      chk("t3_after_data", 32'(P_DATA), 32'h96);

      // 4: P=16, 3-cycle low glitch must be rejected
      PRESCALE = 6'd16;
      snap();
      RX_IN = 1'b0;
      tick(3);
      RX_IN = 1'b1;
      tick(40);
      chk("t4_no_pulse", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
      send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, -1);
      tick(4);
      chk("t4_after_data", 32'(P_DATA), 32'hC3);

      // 5: P=16, 0xF0 with centre-sample spikes on data bit 4 (a 1) and data bit 0 (a 0)
      snap();
      send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, 5);
      tick(4);
      chk("t5_dv_count", 32'(dv_cnt - dv0), 32'd1);
      chk("t5_data",     32'(P_DATA), 32'hF0);
      send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, 1);
      tick(4);
      chk("t5b_data", 32'(dv_log[dv0+1]), 32'hF0);

      // 6: P=8 back-to-back 0x01, 0xFE, reset during a third frame, then a clean frame
      PRESCALE = 6'd8;
      snap();
      send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, -1);
      start2 = start_cyc;
      send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b1, -1);
      chk("t6_gap", 32'(start_cyc - start2), 32'd80);
      RX_IN = 1'b0;
      tick(20);
      chk("t6_dv_count", 32'(dv_cnt - dv0), 32'd2);
      chk("t6_data0",    32'(dv_log[dv0]), 32'h01);
      chk("t6_data1",    32'(dv_log[dv0+1]), 32'hFE);
      #2;
      RST = 1'b0;
      #1;
      chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
      chk("t6_rst_flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
      RX_IN = 1'b1;
      tick(3);
      RST = 1'b1;
      tick(3);
      snap();
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
      tick(4);
      chk("t6_post_dv",   32'(dv_cnt - dv0), 32'd1);
      chk("t6_post_data", 32'(P_DATA), 32'h5A);
      chk("t6_post_err",  32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
